// File: rtl/shadow_collect_pkg.sv
// Shared types for the shadow dump collector: FSM states, the FIFO entry
// layout and the width helper for the word bit-count field.
package shadow_collect_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    COLLECT,
    FLUSH
  } state_e;

  // Width needed to hold a bit count from 0 up to and including word_w.
  function automatic int word_bits_w(input int word_w);
    return $clog2(word_w + 1);
  endfunction

  localparam int DEF_WORD_W = 32;
  localparam int DEF_BITS_W = word_bits_w(DEF_WORD_W);

  // Entry layout for the default word width; wider or narrower collectors
  // declare the same three fields at their own width.
  typedef struct packed {
    logic [DEF_WORD_W-1:0] data;
    logic [DEF_BITS_W-1:0] bits;
    logic                  last;
  } entry_t;

endpackage

// File: rtl/shadow_collect_fifo.sv
// Synchronous FIFO of collector entries; head is read straight from storage,
// an empty FIFO never bypasses a same-cycle push.
module shadow_collect_fifo
  import shadow_collect_pkg::*;
#(
  parameter type entry_t = shadow_collect_pkg::entry_t,
  parameter int  DEPTH   = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  output logic   full_o,
  output logic   empty_o,
  output entry_t head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q;
  logic [PTR_W:0]   rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every register
      // samples pre-edge values regardless of statement order.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage has no reset; validity lives in the pointers, and the head
  // is forced to zero while empty so stale contents never reach the port.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
  end

  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/shadow_dump_collector.sv
// Receiving end of a shadow-capture dump chain: triggers the dump, packs the
// serial stream into words and queues them for the host-side reader.
module shadow_dump_collector
  import shadow_collect_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = 16
) (
  input  logic                           sh_clk,
  input  logic                           sh_rst_n,
  input  logic                           start,
  output logic                           busy,
  output logic                           dump_en,
  input  logic                           ch_out,
  input  logic                           ch_out_vld,
  input  logic                           ch_out_done,
  output logic [WORD_W-1:0]              word_data,
  output logic [word_bits_w(WORD_W)-1:0] word_bits,
  output logic                           word_last,
  output logic                           word_valid,
  input  logic                           word_ready,
  output logic [CNT_W-1:0]               bit_count,
  output logic                           overflow,
  output logic                           timeout_err
);

  localparam int BITS_W = word_bits_w(WORD_W);
  localparam int WD_W   = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [BITS_W-1:0] bits;
    logic              last;
  } word_entry_t;

  state_e            state_q, state_d;
  logic [BITS_W-1:0] fill_q, fill_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              overflow_q, overflow_d;
  logic              timeout_q, timeout_d;
  logic              skip_flush_q, skip_flush_d;

  logic              push;
  word_entry_t       push_entry;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  word_entry_t       head;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // combinational output unassigned and infers a latch.
    state_d      = state_q;
    fill_d       = fill_q;
    acc_d        = acc_q;
    wd_d         = wd_q;
    bit_cnt_d    = bit_cnt_q;
    overflow_d   = overflow_q;
    timeout_d    = timeout_q;
    skip_flush_d = skip_flush_q;
    push         = 1'b0;
    push_entry   = '0;

    unique case (state_q)
      IDLE: begin
        if (start) state_d = ARM;
      end

      ARM: begin
        state_d      = COLLECT;
        fill_d       = '0;
        acc_d        = '0;
        wd_d         = '0;
        bit_cnt_d    = '0;
        overflow_d   = 1'b0;
        timeout_d    = 1'b0;
        skip_flush_d = 1'b0;
      end

      COLLECT: begin
        if (ch_out_vld) begin
          for (int i = 0; i < WORD_W; i++) begin
            if (fill_q == BITS_W'(i)) acc_d[i] = ch_out;
          end
          wd_d = '0;
          if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 1'b1;
          if (fill_q == BITS_W'(WORD_W - 1)) begin
            push            = 1'b1;
            push_entry.data = acc_d;
            push_entry.bits = BITS_W'(WORD_W);
            push_entry.last = ch_out_done;
            fill_d          = '0;
            acc_d           = '0;
            // A word completed by the done-cycle bit already carries last.
            skip_flush_d    = ch_out_done;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end

        if (ch_out_done) begin
          state_d = FLUSH;
          wd_d    = '0;
        end else if (!ch_out_vld) begin
          if (wd_q == WD_W'(TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            state_d   = FLUSH;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end

      FLUSH: begin
        state_d = IDLE;
        if (!skip_flush_q) begin
          push            = 1'b1;
          push_entry.data = acc_q;
          push_entry.bits = fill_q;
          push_entry.last = 1'b1;
        end
      end
    endcase

    if (push && fifo_full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge sh_clk or negedge sh_rst_n) begin
    if (!sh_rst_n) begin
      state_q      <= IDLE;
      fill_q       <= '0;
      acc_q        <= '0;
      wd_q         <= '0;
      bit_cnt_q    <= '0;
      overflow_q   <= 1'b0;
      timeout_q    <= 1'b0;
      skip_flush_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      acc_q        <= acc_d;
      wd_q         <= wd_d;
      bit_cnt_q    <= bit_cnt_d;
      overflow_q   <= overflow_d;
      timeout_q    <= timeout_d;
      skip_flush_q <= skip_flush_d;
    end
  end

  shadow_collect_fifo #(
    .entry_t (word_entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk         (sh_clk),
    .rst_n       (sh_rst_n),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head)
  );

  assign pop         = word_valid && word_ready;
  assign word_valid  = !fifo_empty;
  assign word_data   = head.data;
  assign word_bits   = head.bits;
  assign word_last   = head.last;

  assign busy        = (state_q != IDLE);
  assign dump_en     = (state_q == ARM);
  assign bit_count   = bit_cnt_q;
  assign overflow    = overflow_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_shadow_dump_collector.sv
// Directed bench for shadow_dump_collector; a passive monitor records every
// word the reader accepts, and the directed steps compare against constants.
module tb_shadow_dump_collector;

  localparam int WORD_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 20;
  localparam int CNT_W      = 16;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  bits;
    logic        last;
  } rec_t;

  logic        sh_clk      = 1'b0;
  logic        sh_rst_n    = 1'b0;
  logic        start       = 1'b0;
  logic        ch_out      = 1'b0;
  logic        ch_out_vld  = 1'b0;
  logic        ch_out_done = 1'b0;
  logic        word_ready  = 1'b0;
  logic        busy, dump_en, word_last, word_valid, overflow, timeout_err;
  logic [31:0] word_data;
  logic [5:0]  word_bits;
  logic [15:0] bit_count;

  int   compared   = 0;
  int   mismatched = 0;
  rec_t got[$];

  always #5 sh_clk = ~sh_clk;

  shadow_dump_collector #(
    .WORD_W     (WORD_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .sh_clk      (sh_clk),
    .sh_rst_n    (sh_rst_n),
    .start       (start),
    .busy        (busy),
    .dump_en     (dump_en),
    .ch_out      (ch_out),
    .ch_out_vld  (ch_out_vld),
    .ch_out_done (ch_out_done),
    .word_data   (word_data),
    .word_bits   (word_bits),
    .word_last   (word_last),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .bit_count   (bit_count),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  always @(posedge sh_clk) begin
    if (sh_rst_n && word_valid && word_ready)
      got.push_back('{data: word_data, bits: word_bits, last: word_last});
  end

  task automatic step();
    @(posedge sh_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic last);
    ch_out_vld  = 1'b1;
    ch_out      = b;
    ch_out_done = last;
    step();
    ch_out_vld  = 1'b0;
    ch_out      = 1'b0;
    ch_out_done = 1'b0;
  endtask

  task automatic begin_dump(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_dump_en"}, dump_en, 1);
    check({tag, "_busy"}, busy, 1);
    step();
    check({tag, "_dump_en_off"}, dump_en, 0);
  endtask

  initial begin
    logic [31:0] pat;

    repeat (2) step();
    check("rst_busy", busy, 0);
    check("rst_dump_en", dump_en, 0);
    check("rst_valid", word_valid, 0);
    check("rst_data", word_data, 0);
    check("rst_bits", word_bits, 0);
    check("rst_last", word_last, 0);
    check("rst_count", bit_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_tmo", timeout_err, 0);
    sh_rst_n = 1'b1;
    step();

    // 189 alternating bits starting with 1, reader always ready.
    word_ready = 1'b1;
    got.delete();
    begin_dump("t1");
    for (int i = 0; i < 189; i++) send_bit(~i[0], i == 188);
    check("t1_flush_busy", busy, 1);
    step();
    check("t1_idle_busy", busy, 0);
    check("t1_last_valid", word_valid, 1);
    check("t1_last_flag", word_last, 1);
    step();
    step();
    check("t1_words", got.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < got.size()) begin
        check($sformatf("t1_data%0d", k), got[k].data, (k < 5) ? 32'h5555_5555 : 32'h1555_5555);
        check($sformatf("t1_bits%0d", k), got[k].bits, (k < 5) ? 6'd32 : 6'd29);
        check($sformatf("t1_last%0d", k), got[k].last, (k == 5) ? 1'b1 : 1'b0);
      end
    end
    check("t1_count", bit_count, 189);
    check("t1_ovf", overflow, 0);

    // Exactly 64 bits, done on the 64th.
    got.delete();
    begin_dump("t2");
    for (int i = 0; i < 64; i++) begin
      send_bit(i[0], i == 63);
      if (i == 31) begin
        check("t2_word_valid", word_valid, 1);
        check("t2_word_bits", word_bits, 32);
        check("t2_word_last", word_last, 0);
      end
    end
    check("t2_flush_busy", busy, 1);
    step();
    check("t2_idle_busy", busy, 0);
    repeat (3) step();
    check("t2_words", got.size(), 2);
    if (got.size() == 2) begin
      check("t2_data1", got[1].data, 32'hAAAA_AAAA);
      check("t2_last0", got[0].last, 0);
      check("t2_last1", got[1].last, 1);
    end
    check("t2_count", bit_count, 64);

    // Done with no data bits.
    got.delete();
    begin_dump("t3");
    ch_out_done = 1'b1;
    step();
    ch_out_done = 1'b0;
    repeat (3) step();
    check("t3_words", got.size(), 1);
    if (got.size() == 1) begin
      check("t3_data", got[0].data, 0);
      check("t3_bits", got[0].bits, 0);
      check("t3_last", got[0].last, 1);
    end
    check("t3_count", bit_count, 0);

    // Reader stalled for 200 bits: word k carries value k+1.
    word_ready = 1'b0;
    got.delete();
    begin_dump("t4");
    for (int i = 0; i < 200; i++) begin
      pat = 32'(i / 32 + 1);
      send_bit(pat[i % 32], i == 199);
    end
    repeat (2) step();
    check("t4_ovf", overflow, 1);
    check("t4_busy", busy, 0);
    check("t4_valid", word_valid, 1);
    check("t4_head", word_data, 1);
    word_ready = 1'b1;
    repeat (4) step();
    check("t4_drained", word_valid, 0);
    check("t4_words", got.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < got.size()) begin
        check($sformatf("t4_data%0d", k), got[k].data, k + 1);
        check($sformatf("t4_last%0d", k), got[k].last, 0);
      end
    end
    check("t4_count", bit_count, 200);

    // Five bits then silence until the watchdog fires.
    got.delete();
    begin_dump("t5");
    check("t5_ovf_cleared", overflow, 0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    repeat (TIMEOUT - 1) step();
    check("t5_tmo_early", timeout_err, 0);
    check("t5_busy_early", busy, 1);
    step();
    check("t5_tmo", timeout_err, 1);
    check("t5_flush_busy", busy, 1);
    step();
    check("t5_idle_busy", busy, 0);
    check("t5_valid", word_valid, 1);
    step();
    check("t5_words", got.size(), 1);
    if (got.size() == 1) begin
      check("t5_data", got[0].data, 32'h1F);
      check("t5_bits", got[0].bits, 5);
      check("t5_last", got[0].last, 1);
    end
    check("t5_tmo_sticky", timeout_err, 1);

    // Reset in the middle of a dump, then a clean dump.
    word_ready = 1'b0;
    got.delete();
    begin_dump("t6");
    for (int i = 0; i < 40; i++) send_bit(i[0], 1'b0);
    check("t6_pre_valid", word_valid, 1);
    check("t6_pre_count", bit_count, 40);
    sh_rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_valid", word_valid, 0);
    check("t6_rst_data", word_data, 0);
    check("t6_rst_count", bit_count, 0);
    check("t6_rst_dump_en", dump_en, 0);
    step();
    sh_rst_n = 1'b1;
    step();
    word_ready = 1'b1;
    begin_dump("t6b");
    pat = 32'hDEAD_BEEF;
    for (int i = 0; i < 32; i++) send_bit(pat[i], i == 31);
    repeat (3) step();
    check("t6_words", got.size(), 1);
    if (got.size() == 1) begin
      check("t6_data", got[0].data, 32'hDEAD_BEEF);
      check("t6_bits", got[0].bits, 32);
      check("t6_last", got[0].last, 1);
    end
    check("t6_count", bit_count, 32);
    check("t6_ovf", overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/shadow_dump_collector.md
# shadow_dump_collector

Receiving end of a shadow-capture dump chain. On a start request it pulses the chain's dump enable, then deserializes the 1-bit `ch_out`/`ch_out_vld`/`ch_out_done` stream into WORD_W-bit words. Words are buffered in a small FIFO and presented to a host-side reader over a valid/ready port. The block sits on the shadow clock domain between a core's shadow capture chain output and the debug readout logic.

## Interface
- WORD_W, 32: output word width, in bits; ≥ 2.
- FIFO_DEPTH, 4: number of word entries; power of two, ≥ 2.
- TIMEOUT, 1024: maximum idle cycles between stream events in COLLECT before abort.
- CNT_W, 16: width of the total bit counter.
- sh_clk  in  1  shadow/data clock; the only clock.
- sh_rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to begin a dump; ignored unless IDLE.
- busy  out  1  high in any state other than IDLE.
- dump_en  out  1  to chain; one-cycle pulse that starts the chain dump.
- ch_out  in  1  serial dump data.
- ch_out_vld  in  1  `ch_out` is valid this cycle.
- ch_out_done  in  1  chain has finished streaming.
- word_data  out  WORD_W  FIFO head data; LSB = earliest bit.
- word_bits  out  clog2(WORD_W+1)  count of valid bits in the head word.
- word_last  out  1  head word is the final word of the dump.
- word_valid  out  1  FIFO not empty.
- word_ready  in  1  reader accepts the head word when `word_valid & word_ready`.
- bit_count  out  CNT_W  bits received in the current or last dump; saturates.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- timeout_err  out  1  sticky: the dump was aborted by the watchdog.

## Operation
- States:
  - IDLE -> ARM on `start`.
  - ARM -> COLLECT unconditionally.
  - COLLECT -> FLUSH on `ch_out_done` or watchdog expiry.
  - FLUSH -> IDLE after at most one push.
- ARM:
  - `dump_en` = 1 for exactly this cycle.
  - Clears `bit_count`, the accumulator, the watchdog, `overflow` and `timeout_err`.
  - FIFO contents are not cleared.
- COLLECT:
  - Each `ch_out_vld` cycle shifts `ch_out` into accumulator bit position `fill`, then `fill` increments.
  - When `fill` reaches WORD_W, the word is pushed with bits = WORD_W, last = 0, and `fill` returns to 0.
- `ch_out_done`:
  - A `vld` bit in the same cycle is included.
  - Any `vld` after `done` is ignored.
  - If the same-cycle bit completes a word, that word is pushed with last = 1 and FLUSH pushes nothing.
  - Otherwise FLUSH pushes the partial word: zero-padded upper bits, bits = `fill`, last = 1.
  - If zero bits were received, FLUSH pushes data 0, bits 0, last 1.
- Push when the FIFO is full (a pop in the same cycle frees a slot first): the word is dropped and `overflow` is set. A dropped last word means the reader never sees `word_last`.
- Watchdog:
  - Counts COLLECT cycles with neither `vld` nor `done`; reset by either.
  - Reaching TIMEOUT sets `timeout_err` and enters FLUSH; the partial word is pushed as last.
- `bit_count` increments per accepted bit and saturates at all-ones.
- `start` in any non-IDLE state is ignored; there is no queueing.

## Timing
- Reset values: all outputs 0; state IDLE; FIFO empty.
- `start` at cycle t gives `dump_en` = 1 at t+1 (registered). COLLECT begins at t+2; a `vld` at t+1 is ignored.
- Bit latency: the final bit of a word, accepted at cycle c, gives `word_valid` = 1 at c+1 if the FIFO was empty.
- Done latency: `done` at cycle c gives FLUSH at c+1, the last word visible at c+2, and `busy` = 0 at c+2.
- FIFO: registered head; push and pop in the same cycle are both honored; an empty FIFO does not bypass.
- Reset asserted mid-dump: immediate return to IDLE, FIFO emptied, stickies cleared; the chain is not notified.

## Structure
- Package `shadow_collect_pkg`:
  - state enum {IDLE, ARM, COLLECT, FLUSH};
  - entry struct {data, bits, last};
  - function computing the `word_bits` width.
- Sub-module `shadow_collect_fifo`: synchronous FIFO of entry structs with full/empty, async active-low reset, and depth parameter.
- Top level holds the FSM, accumulator, watchdog and counters.

## Test plan
- 189 bits, alternating 1/0 from 0, `word_ready` held at 1, `done` with the last bit:
  - 6 words out; words 0–4 are 0x55555555 with bits 32;
  - word 5 is 0x15555555 with bits 29, last 1;
  - `bit_count` = 189.
- Exactly 64 bits, `done` on bit 64 → two words, the second with last = 1 and no third word.
- `done` with no `vld` → one word: data 0, bits 0, last 1.
- `word_ready` = 0 and 200 bits streamed → first 4 words retained, `overflow` = 1, FIFO drains 4 words with no last.
- 5 bits then silence → `timeout_err` = 1 after TIMEOUT idle cycles, one word with bits 5, last 1.
- Reset asserted after 40 bits → all outputs 0 at once; a following `start` gives `dump_en` 1 cycle later and a clean dump.
